ad_serial_scan: RTL

//  Parametrised serial-ADC front end. Generates CS/SCLK framing, shifts a channel address out on
//  ad_din, and shifts a DATA_W-bit result in on ad_dout. Supports single-shot (start) and continuous

---
 rtl/ad_serial_scan.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ad_serial_scan.sv
// Serial-ADC front end: CS/SCLK framing, channel address out on ad_din, result in on ad_dout,
// single-shot or continuous frames on a fixed channel or round-robin scan.
module ad_serial_scan #(
    parameter int DATA_W    = 8,
    parameter int ADDR_BITS = 2,
    parameter int CH_N      = 4,
    parameter int HALF      = 25,
    parameter int CS_SETUP  = 74,
    parameter int PERIOD    = 1300
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cont,
    input  logic                 start,
    input  logic                 scan_en,
    input  logic [ADDR_BITS-1:0] ch_sel,
    output logic                 ad_cs_n,
    output logic                 ad_sclk,
    output logic                 ad_din,
    input  logic                 ad_dout,
    output logic [DATA_W-1:0]    dout,
    output logic [ADDR_BITS-1:0] dout_ch,
    output logic                 dout_valid,
    output logic                 busy
);
    localparam int NB  = ADDR_BITS + DATA_W;
    localparam int F_W = $clog2(PERIOD);
    localparam int K_W = $clog2(NB + 1);

    localparam logic [F_W-1:0]       F_LAST   = F_W'(PERIOD - 1);
    localparam logic [F_W-1:0]       EV_FIRST = F_W'(CS_SETUP);
    localparam logic [F_W-1:0]       EV_STEP  = F_W'(HALF);
    localparam logic [K_W-1:0]       K_NB     = K_W'(NB);
    localparam logic [K_W-1:0]       K_LAST   = K_W'(NB - 1);
    localparam logic [K_W-1:0]       K_AB     = K_W'(ADDR_BITS);
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(CH_N - 1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                state_q, state_d;
    logic [F_W-1:0]        f_q, f_d;
    logic [F_W-1:0]        ev_q, ev_d;
    logic [K_W-1:0]        k_q, k_d;
    logic                  rise_q, rise_d;
    logic [ADDR_BITS-1:0]  ch_q, ch_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic [ADDR_BITS-1:0]  dout_ch_q, dout_ch_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_start;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        ev_d        = ev_q;
        k_d         = k_q;
        rise_d      = rise_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        res_d       = res_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        din_d       = din_q;
        dout_d      = dout_q;
        dout_ch_d   = dout_ch_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (start | cont) begin
                    state_d     = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                f_d = f_q + 1'b1;
                if (f_q == '0) begin
                    cs_n_d = 1'b0;
                    sclk_d = 1'b0;
                    din_d  = ch_q[ADDR_BITS-1];
                    addr_d = ch_q << 1;
                end
                // ev_q holds the next SCLK edge; rise_q tells which kind it is
                if (f_q == ev_q && k_q < K_NB) begin
                    ev_d = ev_q + EV_STEP;
                    if (rise_q) begin
                        sclk_d = 1'b1;
                        rise_d = 1'b0;
                        if (k_q >= K_AB) begin
                            res_d = {res_q[DATA_W-2:0], ad_dout};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        rise_d = 1'b1;
                        din_d  = addr_q[ADDR_BITS-1];
                        addr_d = addr_q << 1;
                        k_d    = k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            cs_n_d = 1'b1;
                            din_d  = 1'b0;
                        end
                    end
                end
                if (f_q == F_LAST) begin
                    dout_d    = res_q;
                    dout_ch_d = ch_q;
                    valid_d   = 1'b1;
                    if (cont | start) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            f_d    = '0;
            busy_d = 1'b1;
            ev_d   = EV_FIRST;
            k_d    = '0;
            rise_d = 1'b1;
            res_d  = '0;
            ch_d   = scan_en ? ptr_q : ch_sel;
            if (scan_en) begin
                ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            f_q       <= '0;
            ev_q      <= '0;
            k_q       <= '0;
            rise_q    <= 1'b1;
            ch_q      <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            res_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            ev_q      <= ev_d;
            k_q       <= k_d;
            rise_q    <= rise_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            res_q     <= res_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign ad_cs_n    = cs_n_q;
    assign ad_sclk    = sclk_q;
    assign ad_din     = din_q;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;

endmodule
